// File: rtl/store_buffer.sv
// Per-strand store buffer between the memory stage, writeback and the L2.
// Define STBUF_FORWARD_EN to build in store-to-load forwarding.
`ifndef STRANDS_PER_CORE
`define STRANDS_PER_CORE 4
`endif
`ifndef STRAND_INDEX_WIDTH
`define STRAND_INDEX_WIDTH 2
`endif
`ifndef CACHE_LINE_BITS
`define CACHE_LINE_BITS 512
`endif

module store_buffer (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dcache_store,
    input  logic                           dcache_store_sync,
    input  logic                           dcache_load,
    input  logic [`STRAND_INDEX_WIDTH-1:0] dcache_req_strand,
    input  logic [25:0]                    dcache_request_addr,
    input  logic [`CACHE_LINE_BITS-1:0]    dcache_store_data,
    input  logic [63:0]                    dcache_store_mask,
    output logic                           stbuf_rollback,
    output logic [`CACHE_LINE_BITS-1:0]    stbuf_data,
    output logic [63:0]                    stbuf_mask,
    output logic                           stbuf_sync_success,
    output logic [`STRANDS_PER_CORE-1:0]   stbuf_resume,
    output logic                           l2req_valid,
    input  logic                           l2req_ready,
    output logic                           l2req_sync,
    output logic [`STRAND_INDEX_WIDTH-1:0] l2req_strand,
    output logic [25:0]                    l2req_address,
    output logic [`CACHE_LINE_BITS-1:0]    l2req_data,
    output logic [63:0]                    l2req_mask,
    input  logic                           l2rsp_valid,
    input  logic [`STRAND_INDEX_WIDTH-1:0] l2rsp_strand,
    input  logic                           l2rsp_status
);

    localparam int NS = `STRANDS_PER_CORE;
    localparam int SW = `STRAND_INDEX_WIDTH;
    localparam int LB = `CACHE_LINE_BITS;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ISSUED,
        SYNC_DONE
    } ent_state_t;

    ent_state_t      ent_state [NS];
    logic [25:0]     ent_addr  [NS];
    logic [LB-1:0]   ent_data  [NS];
    logic [63:0]     ent_mask  [NS];
    logic [NS-1:0]   ent_sync;
    logic [NS-1:0]   ent_status;
    logic [SW-1:0]   rr_ptr;

    logic            handshake;
    logic [NS-1:0]   pend;
    logic            grant_valid;
    logic [SW-1:0]   grant;
    logic [SW-1:0]   arb_idx;

    ent_state_t      req_state;
    logic            addr_eq;
    logic            req_capture;
    logic            req_complete;
    logic            req_reject;
    logic            fwd_hit;

    assign handshake = l2req_valid & l2req_ready;

    // The entry being handed off this cycle is masked so it cannot be regranted.
    always_comb begin
        pend        = '0;
        grant_valid = 1'b0;
        grant       = rr_ptr;
        arb_idx     = '0;
        for (int i = 0; i < NS; i++)
            pend[i] = (ent_state[i] == PENDING);
        if (handshake)
            pend[l2req_strand] = 1'b0;
        for (int i = NS; i >= 1; i--) begin
            arb_idx = rr_ptr + SW'(i);
            if (pend[arb_idx]) begin
                grant_valid = 1'b1;
                grant       = arb_idx;
            end
        end
    end

    assign req_state = ent_state[dcache_req_strand];
    assign addr_eq   = (ent_addr[dcache_req_strand] == dcache_request_addr);

    assign req_complete = dcache_store && dcache_store_sync && addr_eq
                          && (req_state == SYNC_DONE);
    assign req_capture  = dcache_store && !req_complete
                          && (req_state == IDLE || req_state == SYNC_DONE);
    assign req_reject   = dcache_store
                          && (req_state == PENDING || req_state == ISSUED);
    assign fwd_hit      = !dcache_store && dcache_load && addr_eq
                          && !ent_sync[dcache_req_strand]
                          && (req_state == PENDING || req_state == ISSUED);

    assign l2req_sync    = l2req_valid & ent_sync[l2req_strand];
    assign l2req_address = l2req_valid ? ent_addr[l2req_strand] : '0;
    assign l2req_data    = l2req_valid ? ent_data[l2req_strand] : '0;
    assign l2req_mask    = l2req_valid ? ent_mask[l2req_strand] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NS; i++)
                ent_state[i] <= IDLE;
            rr_ptr             <= '0;
            l2req_valid        <= 1'b0;
            l2req_strand       <= '0;
            stbuf_rollback     <= 1'b0;
            stbuf_sync_success <= 1'b0;
            stbuf_resume       <= '0;
            stbuf_mask         <= '0;
            stbuf_data         <= '0;
        end else begin
            stbuf_rollback     <= 1'b0;
            stbuf_sync_success <= 1'b0;
            stbuf_resume       <= '0;
            stbuf_mask         <= '0;
            stbuf_data         <= '0;

            if (!l2req_valid || l2req_ready) begin
                l2req_valid <= grant_valid;
                if (grant_valid) begin
                    l2req_strand <= grant;
                    rr_ptr       <= grant;
                end
            end
            if (handshake)
                ent_state[l2req_strand] <= ISSUED;

            if (req_capture) begin
                ent_state[dcache_req_strand]  <= PENDING;
                ent_addr[dcache_req_strand]   <= dcache_request_addr;
                ent_data[dcache_req_strand]   <= dcache_store_data;
                ent_mask[dcache_req_strand]   <= dcache_store_mask;
                ent_sync[dcache_req_strand]   <= dcache_store_sync;
                ent_status[dcache_req_strand] <= 1'b0;
                stbuf_rollback                <= dcache_store_sync;
            end else if (req_complete) begin
                ent_state[dcache_req_strand] <= IDLE;
                stbuf_sync_success <= ent_status[dcache_req_strand];
            end else if (req_reject) begin
                stbuf_rollback <= 1'b1;
            end else if (fwd_hit) begin
`ifdef STBUF_FORWARD_EN
                stbuf_data <= ent_data[dcache_req_strand];
                stbuf_mask <= ent_mask[dcache_req_strand];
`else
                stbuf_rollback <= 1'b1;
`endif
            end

            // Responses apply after the request saw the pre-update state.
            if (l2rsp_valid) begin
                if (ent_state[l2rsp_strand] == ISSUED) begin
                    stbuf_resume[l2rsp_strand] <= 1'b1;
                    if (ent_sync[l2rsp_strand]) begin
                        ent_state[l2rsp_strand]  <= SYNC_DONE;
                        ent_status[l2rsp_strand] <= l2rsp_status;
                    end else begin
                        ent_state[l2rsp_strand] <= IDLE;
                    end
                end else begin
`ifdef SIMULATION
                    $display("store_buffer: error, response for strand %0d not issued",
                             l2rsp_strand);
`endif
                end
            end
        end
    end

endmodule
